// File: rtl/formula_pkg.sv
// Shared definitions for the formula_2 compute pipe and the blocks around it.
//   res_t                   : result word produced by the formula_2 pipe
//   FORMULA_2_PIPE_LATENCY  : cycles from arg_vld to res_vld in the pipe
//   RESULT_BUF_DEPTH_MIN    : smallest result buffer depth that still
//                             sustains one result per cycle
package formula_pkg;

  typedef logic [31:0] res_t;

  localparam int FORMULA_2_PIPE_LATENCY = 4;
  localparam int RESULT_BUF_DEPTH_MIN   = FORMULA_2_PIPE_LATENCY + 2;

endpackage : formula_pkg

// File: rtl/flip_flop_fifo_with_counter.sv
// Flop-based FIFO with an explicit occupancy counter.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write i_data at the clock edge (dropped when full unless popping)
//   i_data   : write data
//   i_pop    : advance the head (ignored when empty)
//   o_data   : head entry, registered storage, no write-through bypass
//   o_empty  : no entries
//   o_full   : depth entries
//   o_count  : current occupancy, 0..depth
module flip_flop_fifo_with_counter #(
  parameter int width = 32,
  parameter int depth = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [width-1:0]               i_data,
  input  logic                           i_pop,
  output logic [width-1:0]               o_data,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(depth+1)-1:0]     o_count
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(depth));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule : flip_flop_fifo_with_counter

// File: rtl/formula_2_result_buffer.sv
// Result buffer behind the formula_2 pipe (which cannot be stalled).
// Results are queued in a FIFO and offered on a valid/ready port; argument
// issue into the pipe is throttled by a credit count so every result that
// comes back is guaranteed a slot.
//   clk, rst      : clock, asynchronous active-high reset
//   issue_vld/rdy : upstream argument handshake; rdy means a credit is free
//   pipe_arg_vld  : gated arg_vld toward the pipe (issue_vld & issue_rdy)
//   res_vld, res  : result stream from the pipe
//   out_vld/rdy   : downstream handshake, out_data is the FIFO head
//   reserved      : results in flight plus results held in the FIFO
//   err           : sticky flag for overflow or an unsolicited result
module formula_2_result_buffer
  import formula_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_vld,
  output logic                           issue_rdy,
  output logic                           pipe_arg_vld,
  input  logic                           res_vld,
  input  logic [width-1:0]               res,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [width-1:0]               out_data,
  output logic [$clog2(depth+1)-1:0]     reserved,
  output logic                           err
);

  localparam int            RW      = $clog2(depth+1);
  localparam logic [RW-1:0] DEPTH_R = RW'(depth);

  logic [RW-1:0] r_reserved;
  logic          r_err;
  logic          w_issue;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [RW-1:0] w_count;
  logic [RW-1:0] w_in_flight;
  logic          w_overflow;
  logic          w_orphan;

  // Credit check looks at the register only, never at out_rdy, so there is
  // no combinational path from the downstream ready to issue_rdy.
  assign issue_rdy    = (r_reserved < DEPTH_R);
  assign w_issue      = issue_vld & issue_rdy;
  assign pipe_arg_vld = w_issue;

  assign out_vld = ~w_empty;
  assign w_pop   = out_vld & out_rdy;

  // reserved counts FIFO entries too, so the difference is what is still
  // travelling through the pipe.
  assign w_in_flight = r_reserved - w_count;
  assign w_overflow  = res_vld & w_full & ~w_pop;
  assign w_orphan    = res_vld & (w_in_flight == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reserved <= '0;
      r_err      <= 1'b0;
    end else begin
      r_reserved <= r_reserved + RW'(w_issue) - RW'(w_pop);
      if (w_overflow | w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

  assign reserved = r_reserved;
  assign err      = r_err;

  flip_flop_fifo_with_counter #(
    .width (width),
    .depth (depth)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (res_vld),
    .i_data  (res),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

endmodule : formula_2_result_buffer
